// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioning block.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int REPEAT_DELAY_DEF    = 50000000;
    localparam int REPEAT_PERIOD_DEF   = 10000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and registered Level/Press/Release.
// Auto-repeat strobes in HELD are built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BtnIn,
    output logic Level,
    output logic Press,
    output logic Release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_debounce_ch: timing parameters must be >= 1");
    end

    logic             sync_p0_q, sync_p1_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rep_fire;
    logic             sync;

    assign sync = sync_p1_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    logic [REP_W-1:0] rep_q, rep_d;

    // Down-counter reloaded on every HELD entry; fires on reaching zero while staying in HELD.
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if ((state_q == PRESS_WAIT && sync && cnt_q == CNT_LAST) ||
            (state_q == RELEASE_WAIT && sync)) begin
            rep_d = REP_W'(REPEAT_DELAY - 1);
        end else if (state_q == HELD && sync) begin
            if (rep_q == '0) begin
                rep_fire = 1'b1;
                rep_d    = REP_W'(REPEAT_PERIOD - 1);
            end else begin
                rep_d = rep_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) rep_q <= '0;
        else     rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                level_d = 1'b1;
                if (!sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else begin
                    press_d = rep_fire;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0_q <= 1'b0;
            sync_p1_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_p0_q <= BtnIn;
            sync_p1_q <= sync_p0_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign Level   = level_q;
    assign Press   = press_q;
    assign Release = release_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// N_BTN independent debounced button channels producing Level plus Press/Release strobes.
// Optional auto-repeat on held buttons: define BTN_AUTOREPEAT_EN.
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BtnIn,
    output logic [N_BTN-1:0] Level,
    output logic [N_BTN-1:0] Press,
    output logic [N_BTN-1:0] Release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .BtnIn   (BtnIn[i]),
            .Level   (Level[i]),
            .Press   (Press[i]),
            .Release (Release[i])
        );
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen with DEBOUNCE_CYCLES=4; j is the edge index relative to the first stimulus sample.
module tb_btn_pulse_gen;

    localparam int N_BTN = 2;

    logic             CLK;
    logic             RST;
    logic [N_BTN-1:0] BtnIn;
    logic [N_BTN-1:0] Level;
    logic [N_BTN-1:0] Press;
    logic [N_BTN-1:0] Release;

    int checks;
    int failures;

    btn_pulse_gen #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BtnIn   (BtnIn),
        .Level   (Level),
        .Press   (Press),
        .Release (Release)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        BtnIn = '0;
        repeat (3) step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] exp_v;
        RST   = 1'b1;
        BtnIn = 2'b11;
        exp_v = '0;
        for (int j = 0; j < 10; j++) begin
            step();
            checks++;
            if ({Level, Press, Release} !== exp_v) begin
                failures++;
                $display("FAIL reset j=%0d got=%b exp=%b", j, {Level, Press, Release}, exp_v);
            end
        end
        do_reset();
    endtask

    task automatic test_clean_press();
        logic [5:0] exp_v;
        for (int j = 0; j <= 32; j++) begin
            BtnIn = (j < 20) ? 2'b01 : 2'b00;
            step();
            exp_v = {1'b0, (j >= 6 && j <= 25), 1'b0, (j == 6), 1'b0, (j == 26)};
            checks++;
            if ({Level, Press, Release} !== exp_v) begin
                failures++;
                $display("FAIL clean_press j=%0d got=%b exp=%b", j, {Level, Press, Release}, exp_v);
            end
        end
        do_reset();
    endtask

    task automatic test_press_bounce();
        logic [5:0] exp_v;
        exp_v = '0;
        for (int j = 0; j <= 20; j++) begin
            BtnIn = (j < 6 && (j % 2) == 0) ? 2'b01 : 2'b00;
            step();
            checks++;
            if ({Level, Press, Release} !== exp_v) begin
                failures++;
                $display("FAIL press_bounce j=%0d got=%b exp=%b", j, {Level, Press, Release}, exp_v);
            end
        end
        do_reset();
    endtask

    task automatic test_release_glitch();
        logic [5:0] exp_v;
        for (int j = 0; j <= 26; j++) begin
            BtnIn = (j < 10 || j == 12) ? 2'b01 : 2'b00;
            step();
            exp_v = {1'b0, (j >= 6 && j <= 18), 1'b0, (j == 6), 1'b0, (j == 19)};
            checks++;
            if ({Level, Press, Release} !== exp_v) begin
                failures++;
                $display("FAIL release_glitch j=%0d got=%b exp=%b", j, {Level, Press, Release}, exp_v);
            end
        end
        do_reset();
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp_v;
        logic       l, p, r;
        for (int j = 0; j <= 24; j++) begin
            BtnIn = (j < 12) ? 2'b11 : 2'b00;
            step();
            l = (j >= 6 && j <= 17);
            p = (j == 6);
            r = (j == 18);
            exp_v = {l, l, p, p, r, r};
            checks++;
            if ({Level, Press, Release} !== exp_v) begin
                failures++;
                $display("FAIL simultaneous j=%0d got=%b exp=%b", j, {Level, Press, Release}, exp_v);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid_debounce();
        logic [5:0] exp_v;
        for (int j = 0; j <= 16; j++) begin
            BtnIn = 2'b01;
            RST   = (j == 5);
            step();
            exp_v = {1'b0, (j >= 12), 1'b0, (j == 12), 1'b0, 1'b0};
            checks++;
            if ({Level, Press, Release} !== exp_v) begin
                failures++;
                $display("FAIL reset_mid_debounce j=%0d got=%b exp=%b", j, {Level, Press, Release}, exp_v);
            end
        end
        RST = 1'b0;
        do_reset();
    endtask

    task automatic test_autorepeat();
        logic [5:0] exp_v;
        logic       p;
        for (int j = 0; j <= 40; j++) begin
            BtnIn = (j < 30) ? 2'b01 : 2'b00;
            step();
`ifdef BTN_AUTOREPEAT_EN
            p = (j == 6) || (j >= 14 && j <= 30 && ((j - 14) % 4) == 0);
`else
            p = (j == 6);
`endif
            exp_v = {1'b0, (j >= 6 && j <= 35), 1'b0, p, 1'b0, (j == 36)};
            checks++;
            if ({Level, Press, Release} !== exp_v) begin
                failures++;
                $display("FAIL autorepeat j=%0d got=%b exp=%b", j, {Level, Press, Release}, exp_v);
            end
        end
        do_reset();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        BtnIn    = '0;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_debounce();
        test_autorepeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
- Conditions raw board push-buttons into clean single-cycle control strobes and debounced levels.
- Sits directly upstream of the CPU halt/pause lock stage.
- Press[] drives the lock's continue (CONT) and pause-request inputs; Level[] is available for LEDs and run-mode switches.
- Each channel has a 2-flop synchronizer, a debounce state machine, and press/release edge generation.

Parameters:
- N_BTN, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change. Must be >= 1. Benches use 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, counter width. Local parameter, derived, not overridable.
- REPEAT_DELAY, 50000000, cycles in HELD before the first auto-repeat. Used only with the optional feature.
- REPEAT_PERIOD, 10000000, cycles between auto-repeat strobes. Used only with the optional feature.

Ports:
- CLK  input  1  system clock, single clock domain.
- RST  input  1  synchronous, active-high reset.
- BtnIn  input  N_BTN  raw asynchronous button pins, 1 = pressed.
- Level  output  N_BTN  debounced button state, registered.
- Press  output  N_BTN  one-cycle strobe on an accepted press, registered.
- Release  output  N_BTN  one-cycle strobe on an accepted release, registered.

Behaviour:
- Reset: synchronous, active-high on CLK. While RST is high, all synchronizer flops, counters, Level, Press and Release are 0, and all FSMs are in IDLE.
- Synchronizer: BtnIn passes through two flops. The FSM input sync equals BtnIn sampled two edges earlier.
- Per-channel FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE: Level = 0. If sync = 1, go to PRESS_WAIT with cnt = 0.
- PRESS_WAIT:
  - sync = 0: return to IDLE (bounce rejected, no output).
  - sync = 1 and cnt == DEBOUNCE_CYCLES-1: go to HELD, set Level = 1, pulse Press for one cycle.
  - Otherwise: cnt increments.
- HELD: Level = 1. If sync = 0, go to RELEASE_WAIT with cnt = 0.
- RELEASE_WAIT: Level stays 1.
  - sync = 1: return to HELD with no new Press.
  - sync = 0 and cnt == DEBOUNCE_CYCLES-1: go to IDLE, set Level = 0, pulse Release for one cycle.
  - Otherwise: cnt increments.
- Latency: BtnIn high at sample edges k..k+DEBOUNCE_CYCLES gives Press and Level rising after edge k+DEBOUNCE_CYCLES+2. Release is symmetric.
- Press and Release are never asserted together on one channel. Each is asserted for at most one consecutive cycle, except under auto-repeat.
- Channels are fully independent. Simultaneous events on several channels assert their strobes in the same cycle.
- Reset mid-operation: the FSM returns to IDLE at once and any pending strobe is dropped. A button still held after RST falls is re-debounced from scratch and produces a new Press.
- The counter saturates by construction and never wraps.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In HELD, a per-channel repeat counter starts at the HELD entry.
  - An extra one-cycle Press fires REPEAT_DELAY cycles after the entry Press, then every REPEAT_PERIOD cycles while the FSM stays in HELD.
  - The counter clears when HELD is left, including on a return from RELEASE_WAIT.
- Undefined: exactly one Press per accepted press. No repeat counter logic is synthesized.

Decomposition:
- Shared package btn_pkg holds:
  - the FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, 2 bits);
  - default values for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
- Sub-module btn_debounce_ch implements one channel: synchronizer, FSM, counters, and one Level/Press/Release bit.
- The top generates N_BTN instances.

Test Plan (DEBOUNCE_CYCLES=4, N_BTN=2 unless stated):
1. Clean press: BtnIn[0] rises at edge 10 and holds for 20 cycles → Press[0] is high for one cycle after edge 16. Level[0] = 1 from the same cycle. No Release.
2. Press bounce: BtnIn[0] = 1,0,1,0,1,0, then stays 0 → Press[0] never asserts and Level[0] stays 0.
3. Release glitch: while held, BtnIn[0] = 0,0,1, then stable 0 → no Release on the glitch. Exactly one Release[0] follows the 5th consecutive 0 sample, plus 2 cycles. Level[0] falls with Release[0].
4. Simultaneous channels: BtnIn = 2'b11 at edge 10, held → Press = 2'b11 in the single cycle after edge 16.
5. Reset mid-debounce: RST is pulsed for one cycle while channel 0 is in PRESS_WAIT with cnt = 2, button still held → no strobe during RST. Press[0] fires after edge (RST-low edge + 6).
6. With BTN_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, button held 30 cycles → Press[0] at HELD entry, then at entry+8, +12, +16, +20, +24. Without the macro: one Press only.
